// File: rtl/var_states_bin_io.sv
// Bridge between per-bin variable-state memory and the Sat Engine state array (LOAD / STORE).
// Optional macro VAR_STATES_IO_SKIP_FREE_EN: STORE suppresses writes of unassigned (value 0) variables.
module var_states_bin_io #(
    parameter int NUM_VARS         = 8,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_ADDR       = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_load_i,
    input  logic                                 start_store_i,
    input  logic [WIDTH_ADDR-1:0]                base_addr_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 mem_rd_en_o,
    output logic [WIDTH_ADDR-1:0]                mem_rd_addr_o,
    input  logic [WIDTH_VAR_STATES-1:0]          mem_rd_data_i,
    output logic                                 mem_wr_en_o,
    output logic [WIDTH_ADDR-1:0]                mem_wr_addr_o,
    output logic [WIDTH_VAR_STATES-1:0]          mem_wr_data_o,
    output logic [NUM_VARS-1:0]                  wr_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i
);

    localparam int CW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam int W  = WIDTH_VAR_STATES;
    localparam int PW = WIDTH_VAR_STATES * NUM_VARS;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_RD,
        LOAD_DRAIN,
        STORE_WR,
        DONE
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [WIDTH_ADDR-1:0] r_base;
    logic [PW-1:0]         r_snap;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rdEn;
    logic [WIDTH_ADDR-1:0] r_rdAddr;
    logic                  r_wrEn;
    logic [WIDTH_ADDR-1:0] r_wrAddr;
    logic [W-1:0]          r_wrData;
    logic [NUM_VARS-1:0]   r_wrStates;

    logic [CW-1:0]         w_nextIdx;
    logic [WIDTH_ADDR-1:0] w_nextAddr;
    logic [W-1:0]          w_nextWord;
    logic [W-1:0]          w_firstWord;
    logic                  w_nextKeep;
    logic                  w_firstKeep;
    logic                  w_lastIdx;
    logic [NUM_VARS-1:0]   w_strobe;

    // Variable 0 sits in the most significant slot of the packed bus.
    function automatic logic [W-1:0] slotOf(input logic [PW-1:0] bus, input logic [CW-1:0] idx);
        slotOf = bus[W*(NUM_VARS-1-int'(idx)) +: W];
    endfunction

    assign w_nextIdx   = r_cnt + CW'(1);
    assign w_nextAddr  = r_base + WIDTH_ADDR'(w_nextIdx);
    assign w_nextWord  = slotOf(r_snap, w_nextIdx);
    assign w_firstWord = slotOf(vars_states_i, '0);
    assign w_lastIdx   = (r_cnt == CW'(NUM_VARS-1));

`ifdef VAR_STATES_IO_SKIP_FREE_EN
    assign w_nextKeep  = |w_nextWord[W-1 -: 3];
    assign w_firstKeep = |w_firstWord[W-1 -: 3];
`else
    assign w_nextKeep  = 1'b1;
    assign w_firstKeep = 1'b1;
`endif

    always_comb begin
        w_strobe = '0;
        for (int i = 0; i < NUM_VARS; i++) begin
            w_strobe[i] = (r_cnt == CW'(NUM_VARS-1-i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_base     <= '0;
            r_snap     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rdEn     <= 1'b0;
            r_rdAddr   <= '0;
            r_wrEn     <= 1'b0;
            r_wrAddr   <= '0;
            r_wrData   <= '0;
            r_wrStates <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rdEn     <= 1'b0;
            r_rdAddr   <= '0;
            r_wrEn     <= 1'b0;
            r_wrAddr   <= '0;
            r_wrData   <= '0;
            r_wrStates <= '0;
            case (r_state)
                IDLE: begin
                    if (start_load_i) begin
                        r_base   <= base_addr_i;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_rdEn   <= 1'b1;
                        r_rdAddr <= base_addr_i;
                        r_state  <= LOAD_RD;
                    end else if (start_store_i) begin
                        r_base   <= base_addr_i;
                        r_snap   <= vars_states_i;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_wrEn   <= w_firstKeep;
                        r_wrAddr <= base_addr_i;
                        r_wrData <= w_firstWord;
                        r_state  <= STORE_WR;
                    end
                end
                LOAD_RD: begin
                    // The strobe for read k lines up with its returning data one cycle later.
                    r_wrStates <= w_strobe;
                    if (w_lastIdx) begin
                        r_state <= LOAD_DRAIN;
                    end else begin
                        r_cnt    <= w_nextIdx;
                        r_rdEn   <= 1'b1;
                        r_rdAddr <= w_nextAddr;
                    end
                end
                LOAD_DRAIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                STORE_WR: begin
                    if (w_lastIdx) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt    <= w_nextIdx;
                        r_wrEn   <= w_nextKeep;
                        r_wrAddr <= w_nextAddr;
                        r_wrData <= w_nextWord;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Memory data arrives in the strobe cycle, so the registered strobe steers it into its slot.
    for (genvar g = 0; g < NUM_VARS; g++) begin : g_slot
        assign vars_states_o[W*(NUM_VARS-g)-1 -: W] = r_wrStates[NUM_VARS-1-g] ? mem_rd_data_i : '0;
    end

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign mem_rd_en_o   = r_rdEn;
    assign mem_rd_addr_o = r_rdAddr;
    assign mem_wr_en_o   = r_wrEn;
    assign mem_wr_addr_o = r_wrAddr;
    assign mem_wr_data_o = r_wrData;
    assign wr_states_o   = r_wrStates;

endmodule

// File: tb/tb_var_states_bin_io.sv
// Scoreboard bench for var_states_bin_io: LOAD, STORE, address wrap, command priority, mid-op reset.
// Honours VAR_STATES_IO_SKIP_FREE_EN when predicting STORE write enables.
module tb_var_states_bin_io;

    localparam int N = 8;
    localparam int W = 19;
    localparam int A = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_load_i = 1'b0;
    logic             start_store_i = 1'b0;
    logic [A-1:0]     base_addr_i = '0;
    logic [W-1:0]     mem_rd_data_i = '0;
    logic [W*N-1:0]   vars_states_i = '0;
    logic             busy_o;
    logic             done_o;
    logic             mem_rd_en_o;
    logic [A-1:0]     mem_rd_addr_o;
    logic             mem_wr_en_o;
    logic [A-1:0]     mem_wr_addr_o;
    logic [W-1:0]     mem_wr_data_o;
    logic [N-1:0]     wr_states_o;
    logic [W*N-1:0]   vars_states_o;

    logic [W-1:0]     mem [0:65535];

    int checks = 0;
    int failures = 0;

    logic [A-1:0]     rdQ[$];
    logic [N-1:0]     strobeQ[$];
    logic [W*N-1:0]   slotQ[$];
    logic [A-1:0]     wrAddrQ[$];
    logic [W-1:0]     wrDataQ[$];

    var_states_bin_io #(
        .NUM_VARS(N),
        .WIDTH_VAR_STATES(W),
        .WIDTH_ADDR(A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_load_i(start_load_i),
        .start_store_i(start_store_i),
        .base_addr_i(base_addr_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .mem_rd_en_o(mem_rd_en_o),
        .mem_rd_addr_o(mem_rd_addr_o),
        .mem_rd_data_i(mem_rd_data_i),
        .mem_wr_en_o(mem_wr_en_o),
        .mem_wr_addr_o(mem_wr_addr_o),
        .mem_wr_data_o(mem_wr_data_o),
        .wr_states_o(wr_states_o),
        .vars_states_o(vars_states_o),
        .vars_states_i(vars_states_i)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (mem_rd_en_o) mem_rd_data_i <= mem[mem_rd_addr_o];
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_o, done_o, mem_rd_en_o, mem_wr_en_o} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%b exp=0000", {busy_o, done_o, mem_rd_en_o, mem_wr_en_o});
        end
        checks++;
        if ({mem_rd_addr_o, mem_wr_addr_o, mem_wr_data_o} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mem_bus got=%h exp=0", {mem_rd_addr_o, mem_wr_addr_o, mem_wr_data_o});
        end
        checks++;
        if ({wr_states_o, vars_states_o} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_array got=%h exp=0", {wr_states_o, vars_states_o});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // LOAD from base; optionally assert start_store together with start_load and again mid-run.
    task automatic test_load(input logic [A-1:0] base, input bit bothStart, input string name);
        logic [A-1:0]   a;
        logic [W-1:0]   wd;
        logic [N-1:0]   s;
        logic [W*N-1:0] pk;
        logic           expRd;
        logic           expStb;
        for (int i = 0; i < N; i++) begin
            a = base + A'(i);
            wd = {3'(i % 4), 16'(100 + i)};
            mem[a] = wd;
            rdQ.push_back(a);
            s = '0;
            s[N-1-i] = 1'b1;
            pk = '0;
            pk[W*(N-1-i) +: W] = wd;
            strobeQ.push_back(s);
            slotQ.push_back(pk);
        end
        start_load_i = 1'b1;
        start_store_i = bothStart;
        base_addr_i = base;
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            expRd = (c <= N);
            checks++;
            if (mem_rd_en_o !== expRd) begin
                failures++;
                $display("[TB] FAIL %s rd_en c=%0d got=%b exp=%b", name, c, mem_rd_en_o, expRd);
            end
            if (expRd) begin
                checks++;
                if (rdQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL %s rd_queue_empty c=%0d", name, c);
                end else begin
                    a = rdQ.pop_front();
                    if (mem_rd_addr_o !== a) begin
                        failures++;
                        $display("[TB] FAIL %s rd_addr c=%0d got=%h exp=%h", name, c, mem_rd_addr_o, a);
                    end
                end
            end
            expStb = (c >= 2 && c <= N + 1);
            if (expStb) begin
                checks++;
                if (strobeQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL %s strobe_queue_empty c=%0d", name, c);
                end else begin
                    s = strobeQ.pop_front();
                    pk = slotQ.pop_front();
                    if (wr_states_o !== s || vars_states_o !== pk) begin
                        failures++;
                        $display("[TB] FAIL %s strobe c=%0d got=%h/%h exp=%h/%h", name, c,
                                 wr_states_o, vars_states_o, s, pk);
                    end
                end
            end else begin
                checks++;
                if (wr_states_o !== '0 || vars_states_o !== '0) begin
                    failures++;
                    $display("[TB] FAIL %s idle_array c=%0d got=%h/%h exp=0", name, c, wr_states_o, vars_states_o);
                end
            end
            checks++;
            if (mem_wr_en_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s wr_en c=%0d got=%b exp=0", name, c, mem_wr_en_o);
            end
            checks++;
            if (done_o !== (c == N + 2) || busy_o !== (c <= N + 1)) begin
                failures++;
                $display("[TB] FAIL %s done_busy c=%0d got=%b%b exp=%b%b", name, c, done_o, busy_o,
                         (c == N + 2), (c <= N + 1));
            end
            if (c == 1) begin
                start_load_i = 1'b0;
                start_store_i = 1'b0;
            end
            if (bothStart && c == 4) begin
                start_store_i = 1'b1;
                base_addr_i = 16'h0300;
            end
            if (c == 5) start_store_i = 1'b0;
        end
        checks++;
        if (rdQ.size() != 0 || strobeQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s leftover got=%0d/%0d exp=0/0", name, rdQ.size(), strobeQ.size());
            rdQ.delete();
            strobeQ.delete();
            slotQ.delete();
        end
    endtask

    // STORE to 0x0200; zeroMask marks variables whose value field is 0.
    task automatic test_store(input logic [N-1:0] zeroMask, input string name);
        logic [A-1:0]   base;
        logic [W-1:0]   wd;
        logic [W*N-1:0] pk;
        logic [N-1:0]   keep;
        logic [A-1:0]   a;
        logic           expWr;
        base = 16'h0200;
        pk = '0;
        for (int i = 0; i < N; i++) begin
            wd = zeroMask[i] ? {3'b000, 16'(i * 3)} : {3'b011, 16'(i * 3)};
            pk[W*(N-1-i) +: W] = wd;
`ifdef VAR_STATES_IO_SKIP_FREE_EN
            keep[i] = !zeroMask[i];
`else
            keep[i] = 1'b1;
`endif
            if (keep[i]) begin
                wrAddrQ.push_back(base + A'(i));
                wrDataQ.push_back(wd);
            end
        end
        vars_states_i = pk;
        start_store_i = 1'b1;
        base_addr_i = base;
        for (int c = 1; c <= N + 2; c++) begin
            @(negedge clk);
            expWr = 1'b0;
            if (c <= N) expWr = keep[c-1];
            checks++;
            if (mem_wr_en_o !== expWr) begin
                failures++;
                $display("[TB] FAIL %s wr_en c=%0d got=%b exp=%b", name, c, mem_wr_en_o, expWr);
            end
            if (expWr) begin
                checks++;
                if (wrAddrQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL %s wr_queue_empty c=%0d", name, c);
                end else begin
                    a = wrAddrQ.pop_front();
                    wd = wrDataQ.pop_front();
                    if (mem_wr_addr_o !== a || mem_wr_data_o !== wd) begin
                        failures++;
                        $display("[TB] FAIL %s wr_word c=%0d got=%h:%h exp=%h:%h", name, c,
                                 mem_wr_addr_o, mem_wr_data_o, a, wd);
                    end
                end
            end
            checks++;
            if (mem_rd_en_o !== 1'b0 || wr_states_o !== '0) begin
                failures++;
                $display("[TB] FAIL %s no_load_side c=%0d got=%b/%h exp=0/0", name, c, mem_rd_en_o, wr_states_o);
            end
            checks++;
            if (done_o !== (c == N + 1) || busy_o !== (c <= N)) begin
                failures++;
                $display("[TB] FAIL %s done_busy c=%0d got=%b%b exp=%b%b", name, c, done_o, busy_o,
                         (c == N + 1), (c <= N));
            end
            if (c == 1) begin
                start_store_i = 1'b0;
                vars_states_i = ~pk;
                base_addr_i = 16'h0BAD;
            end
        end
        checks++;
        if (wrAddrQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s wr_leftover got=%0d exp=0", name, wrAddrQ.size());
            wrAddrQ.delete();
            wrDataQ.delete();
        end
    endtask

    task automatic test_reset_midop();
        start_load_i = 1'b1;
        base_addr_i = 16'h0040;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (busy_o !== 1'b1) begin
                failures++;
                $display("[TB] FAIL midop_busy c=%0d got=%b exp=1", c, busy_o);
            end
            start_load_i = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_o, done_o, mem_rd_en_o, mem_wr_en_o, mem_rd_addr_o, wr_states_o, vars_states_o} !== '0) begin
            failures++;
            $display("[TB] FAIL midop_reset_outputs got=%b%b%b%b %h %h exp=all0", busy_o, done_o,
                     mem_rd_en_o, mem_wr_en_o, mem_rd_addr_o, wr_states_o);
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({busy_o, done_o, mem_rd_en_o, wr_states_o} !== '0) begin
                failures++;
                $display("[TB] FAIL midop_quiet c=%0d got=%b%b%b %h exp=0", c, busy_o, done_o,
                         mem_rd_en_o, wr_states_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load(16'h0010, 1'b0, "load");
        test_store(8'h00, "store");
        test_load(16'hFFFE, 1'b0, "wrap");
        test_load(16'h0020, 1'b1, "both_start");
        test_reset_midop();
        test_load(16'h0050, 1'b0, "post_reset");
        test_store(8'h24, "skip_free");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/var_states_bin_io.md
Name: var_states_bin_io

Overview:
- Sequential bridge between the per-bin variable-state memory and the Sat Engine variable-state array.
- LOAD: reads NUM_VARS state words from memory and writes them into the array one variable per cycle through the array's one-hot write strobes and packed state bus.
- STORE: snapshots the array's packed state output and writes it back to memory one word per cycle.
- Driven by the bin-switch controller: LOAD when a bin is swapped in, STORE when it is swapped out.

Parameters:
- NUM_VARS, 8, variables per engine; power of two, 2..64.
- WIDTH_VAR_STATES, 19, bits per state word: [18:16] value (3 bits), [15:0] level (16 bits).
- WIDTH_ADDR, 16, memory word address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start_load_i  in  1  single-cycle command pulse.
- start_store_i  in  1  single-cycle command pulse.
- base_addr_i  in  WIDTH_ADDR  address of variable 0's word; sampled with the start pulse.
- busy_o  out  1  high while a LOAD or STORE is in progress.
- done_o  out  1  one-cycle pulse on completion.
- mem_rd_en_o  out  1  memory read enable.
- mem_rd_addr_o  out  WIDTH_ADDR  read address.
- mem_rd_data_i  in  WIDTH_VAR_STATES  read data, valid exactly 1 cycle after mem_rd_en_o.
- mem_wr_en_o  out  1  memory write enable.
- mem_wr_addr_o  out  WIDTH_ADDR  write address.
- mem_wr_data_o  out  WIDTH_VAR_STATES  write data.
- wr_states_o  out  NUM_VARS  one-hot write strobe to the array.
- vars_states_o  out  WIDTH_VAR_STATES*NUM_VARS  packed write data to the array.
- vars_states_i  in  WIDTH_VAR_STATES*NUM_VARS  packed state read back from the array.

Behaviour:
- Reset: synchronous on rst; every output is 0 and the FSM is in IDLE.
- Reset mid-operation: the FSM aborts to IDLE, no further strobes or writes are issued, and done_o is not pulsed.
- Variable mapping:
  - Variable i (0..NUM_VARS-1) occupies packed bits [WIDTH_VAR_STATES*(NUM_VARS-i)-1 : WIDTH_VAR_STATES*(NUM_VARS-1-i)], so variable 0 is the most significant slot.
  - Variable i's strobe is wr_states_o[NUM_VARS-1-i].
  - Variable i's memory word is at base_addr_i+i, modulo 2^WIDTH_ADDR; the address wraps silently.
- FSM states: IDLE, LOAD_RD, LOAD_DRAIN, STORE_WR, DONE.
- IDLE transitions:
  - start_load_i=1: latch base, go to LOAD_RD.
  - start_store_i=1 (and start_load_i=0): latch base, register vars_states_i into a snapshot, go to STORE_WR.
  - Both asserted together: LOAD wins; the store command is dropped.
  - Any start outside IDLE is ignored.
- LOAD_RD (NUM_VARS cycles, counter k=0..NUM_VARS-1): mem_rd_en_o=1, mem_rd_addr_o=base+k. After k=NUM_VARS-1, go to LOAD_DRAIN.
- Array write pipeline, active in LOAD_RD and LOAD_DRAIN: one cycle after each read, exactly one wr_states_o bit is asserted for variable k-1. vars_states_o carries mem_rd_data_i in that variable's slot and zeros in every other slot. Strobe and data are registered outputs. When no strobe is asserted, vars_states_o=0.
- LOAD_DRAIN (1 cycle): the final strobe is issued, then go to DONE.
- STORE_WR (NUM_VARS cycles, k=0..NUM_VARS-1): mem_wr_en_o=1, mem_wr_addr_o=base+k, mem_wr_data_o=snapshot slot k. Later changes on vars_states_i have no effect. After k=NUM_VARS-1, go to DONE.
- DONE (1 cycle): done_o=1, busy_o=0, then go to IDLE. A start pulse arriving in DONE is ignored.
- Timing: start pulse sampled at edge T.
  - LOAD: reads occupy cycles T+1..T+NUM_VARS, strobes occupy T+2..T+NUM_VARS+1, done_o is at T+NUM_VARS+2.
  - STORE: writes occupy T+1..T+NUM_VARS, done_o is at T+NUM_VARS+1.
- busy_o=1 in LOAD_RD, LOAD_DRAIN and STORE_WR.
- mem_rd_en_o and mem_wr_en_o are never high in the same cycle.

Optional Feature:
- Macro: VAR_STATES_IO_SKIP_FREE_EN.
- Defined: during STORE, a variable whose snapshot value field [18:16]==3'b000 (unassigned) gets mem_wr_en_o=0 in its slot cycle. The cycle is still consumed and the address still advances, so latency is unchanged.
- Undefined: all NUM_VARS words are written unconditionally.

Test Plan:
- LOAD: NUM_VARS=8, base=0x0010, memory[0x10+i]={3'd(i%4),16'd(100+i)} -> wr_states_o pulses 8'h80,8'h40,...,8'h01 on consecutive cycles T+2..T+9. Each pulse has the matching slot data with all other slots 0. done_o at T+10. busy_o high T+1..T+9.
- STORE: vars_states_i holds var i={3'b011,16'd(i*3)}. Drive start_store_i, then change vars_states_i the next cycle -> writes to 0x0200..0x0207 carry the original snapshot. done_o at T+9.
- Wrap: LOAD with base=0xFFFE -> read addresses 0xFFFE, 0xFFFF, 0x0000..0x0005.
- Simultaneous start_load_i and start_store_i -> only the LOAD sequence occurs, with no mem_wr_en_o. A start_store_i pulse at T+4 is ignored.
- Reset at T+5 during LOAD -> the next cycle has all outputs 0 and no done_o. A fresh LOAD afterwards completes normally.
- With VAR_STATES_IO_SKIP_FREE_EN, STORE with vars 2 and 5 having value 0 -> mem_wr_en_o low at T+3 and T+6, done_o still at T+9. Without the macro, all 8 writes are issued.
